// File: rtl/flash_pkg.sv
// Shared types and constants for the word-fetch front end of the SPI flash byte reader.
package flash_pkg;

   localparam int FLASH_ADDR_W = 24;
   localparam int WORD_BYTES   = 4;
   localparam int WORD_ADDR_W  = FLASH_ADDR_W - 2;
   localparam logic [31:0] DEF_ERR_DATA = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_RELEASE = 2'd2,
      ST_RESP    = 2'd3
   } state_e;

   function automatic logic [FLASH_ADDR_W-1:0] byte_addr(
      input logic [WORD_ADDR_W-1:0] waddr,
      input logic [1:0]             idx
   );
      return {waddr, idx};
   endfunction

endpackage

// File: rtl/flash_word_fetch_if.sv
// CPU word-fetch port plus flash controller byte handshake, bundled for the fetch block.
interface flash_word_fetch_if;
   import flash_pkg::*;

   logic                    cpu_valid;
   logic [FLASH_ADDR_W-1:0] cpu_addr;
   logic [31:0]             cpu_rdata;
   logic                    cpu_ready;
   logic                    cpu_err;
   logic                    flush;
   logic                    fl_valid;
   logic [FLASH_ADDR_W-1:0] fl_addr;
   logic [7:0]              fl_data;
   logic                    fl_ready;

   modport master (
      output cpu_valid, cpu_addr, flush, fl_data, fl_ready,
      input  cpu_rdata, cpu_ready, cpu_err, fl_valid, fl_addr
   );

   modport slave (
      input  cpu_valid, cpu_addr, flush, fl_data, fl_ready,
      output cpu_rdata, cpu_ready, cpu_err, fl_valid, fl_addr
   );

endinterface

// File: rtl/flash_word_buf.sv
// One-entry word buffer: tag/valid/data with combinational lookup, load and flush.
module flash_word_buf
   import flash_pkg::*;
#(
   parameter int BUF_EN = 1
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic [WORD_ADDR_W-1:0] lookup_tag_i,
   output logic                   hit_o,
   output logic [31:0]            data_o,
   input  logic                   load_i,
   input  logic [WORD_ADDR_W-1:0] load_tag_i,
   input  logic [31:0]            load_data_i,
   input  logic                   flush_i
);

   logic                   valid_q, valid_d;
   logic [WORD_ADDR_W-1:0] tag_q, tag_d;
   logic [31:0]            data_q, data_d;

   assign hit_o  = (BUF_EN != 0) && valid_q && (tag_q == lookup_tag_i);
   assign data_o = data_q;

   // Flush wins over a simultaneous load so a stale word is never kept.
   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      data_d  = data_q;
      if (flush_i) begin
         valid_d = 1'b0;
      end else if (load_i) begin
         valid_d = 1'b1;
         tag_d   = load_tag_i;
         data_d  = load_data_i;
      end else begin
         valid_d = valid_q;
      end
   end

   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         valid_q <= 1'b0;
         tag_q   <= '0;
         data_q  <= 32'h0000_0000;
      end else begin
         valid_q <= valid_d;
         tag_q   <= tag_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: rtl/flash_word_fetch.sv
// Splits a 32-bit CPU fetch into four flash byte handshakes, assembles the word
// little-endian, serves repeats from a one-word buffer and aborts hung bytes.
module flash_word_fetch
   import flash_pkg::*;
#(
   parameter int          TIMEOUT_CYCLES = 4096,
   parameter int          BUF_EN         = 1,
   parameter logic [31:0] ERR_DATA       = DEF_ERR_DATA
) (
   input logic               clk,
   input logic               rstn,
   flash_word_fetch_if.slave bus
);

   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

   state_e                  state_q, state_d;
   logic [WORD_ADDR_W-1:0]  waddr_q, waddr_d;
   logic [1:0]              idx_q, idx_d;
   logic [TMR_W-1:0]        timer_q, timer_d;
   logic [31:0]             word_q, word_d;
   logic                    timeout_q, timeout_d;
   logic                    flush_seen_q, flush_seen_d;
   logic                    abandon_q, abandon_d;
   logic                    fl_valid_q, fl_valid_d;
   logic [FLASH_ADDR_W-1:0] fl_addr_q, fl_addr_d;
   logic                    cpu_ready_q, cpu_ready_d;
   logic                    cpu_err_q, cpu_err_d;
   logic [31:0]             cpu_rdata_q, cpu_rdata_d;

   logic                    buf_hit_s;
   logic [31:0]             buf_data_s;
   logic                    buf_load_s;
   logic                    buf_flush_s;
   logic                    addr_lo_unused_s;

   assign addr_lo_unused_s = ^bus.cpu_addr[1:0];

   flash_word_buf #(.BUF_EN(BUF_EN)) u_buf (
      .clk          (clk),
      .rstn         (rstn),
      .lookup_tag_i (bus.cpu_addr[FLASH_ADDR_W-1:2]),
      .hit_o        (buf_hit_s),
      .data_o       (buf_data_s),
      .load_i       (buf_load_s),
      .load_tag_i   (waddr_q),
      .load_data_i  (word_q),
      .flush_i      (buf_flush_s)
   );

   assign bus.fl_valid  = fl_valid_q;
   assign bus.fl_addr   = fl_addr_q;
   assign bus.cpu_ready = cpu_ready_q;
   assign bus.cpu_err   = cpu_err_q;
   assign bus.cpu_rdata = cpu_rdata_q;

   // Next-state, byte assembly, watchdog and buffer control.
   always_comb begin
      state_d      = state_q;
      waddr_d      = waddr_q;
      idx_d        = idx_q;
      timer_d      = timer_q;
      word_d       = word_q;
      timeout_d    = timeout_q;
      flush_seen_d = flush_seen_q;
      abandon_d    = abandon_q;
      fl_valid_d   = fl_valid_q;
      fl_addr_d    = fl_addr_q;
      cpu_ready_d  = 1'b0;
      cpu_err_d    = 1'b0;
      cpu_rdata_d  = cpu_rdata_q;
      buf_load_s   = 1'b0;
      buf_flush_s  = bus.flush;

      case (state_q)
         ST_IDLE: begin
            timer_d   = '0;
            timeout_d = 1'b0;
            // The cycle carrying the ready pulse still sees the old cpu_valid.
            if (bus.cpu_valid && !cpu_ready_q) begin
               if (buf_hit_s && !bus.flush) begin
                  cpu_ready_d = 1'b1;
                  cpu_rdata_d = buf_data_s;
               end else begin
                  waddr_d      = bus.cpu_addr[FLASH_ADDR_W-1:2];
                  idx_d        = 2'd0;
                  fl_addr_d    = byte_addr(bus.cpu_addr[FLASH_ADDR_W-1:2], 2'd0);
                  fl_valid_d   = 1'b1;
                  flush_seen_d = 1'b0;
                  abandon_d    = 1'b0;
                  state_d      = ST_REQ;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_REQ: begin
            flush_seen_d = flush_seen_q | bus.flush;
            abandon_d    = abandon_q | ~bus.cpu_valid;
            if (bus.fl_ready) begin
               word_d[{idx_q, 3'b000} +: 8] = bus.fl_data;
               fl_valid_d = 1'b0;
               timer_d    = '0;
               state_d    = ST_RELEASE;
            end else if (timer_q == TMR_LAST) begin
               fl_valid_d = 1'b0;
               timeout_d  = 1'b1;
               timer_d    = '0;
               state_d    = ST_RELEASE;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end

         ST_RELEASE: begin
            flush_seen_d = flush_seen_q | bus.flush;
            abandon_d    = abandon_q | ~bus.cpu_valid;
            if (!bus.fl_ready) begin
               if (timeout_q || (idx_q == 2'd3)) begin
                  state_d = ST_RESP;
               end else begin
                  idx_d      = idx_q + 2'd1;
                  fl_addr_d  = byte_addr(waddr_q, idx_q + 2'd1);
                  fl_valid_d = 1'b1;
                  state_d    = ST_REQ;
               end
            end else begin
               state_d = ST_RELEASE;
            end
         end

         ST_RESP: begin
            state_d = ST_IDLE;
            if (!abandon_q && bus.cpu_valid) begin
               cpu_ready_d = 1'b1;
               cpu_err_d   = timeout_q;
               cpu_rdata_d = timeout_q ? ERR_DATA : word_q;
            end else begin
               cpu_ready_d = 1'b0;
            end
            if (timeout_q) begin
               buf_flush_s = 1'b1;
            end else begin
               buf_load_s = ~(flush_seen_q | bus.flush);
            end
         end

         default: begin
            state_d    = ST_IDLE;
            fl_valid_d = 1'b0;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         state_q      <= ST_IDLE;
         waddr_q      <= '0;
         idx_q        <= 2'd0;
         timer_q      <= '0;
         word_q       <= 32'h0000_0000;
         timeout_q    <= 1'b0;
         flush_seen_q <= 1'b0;
         abandon_q    <= 1'b0;
         fl_valid_q   <= 1'b0;
         fl_addr_q    <= '0;
         cpu_ready_q  <= 1'b0;
         cpu_err_q    <= 1'b0;
         cpu_rdata_q  <= 32'h0000_0000;
      end else begin
         state_q      <= state_d;
         waddr_q      <= waddr_d;
         idx_q        <= idx_d;
         timer_q      <= timer_d;
         word_q       <= word_d;
         timeout_q    <= timeout_d;
         flush_seen_q <= flush_seen_d;
         abandon_q    <= abandon_d;
         fl_valid_q   <= fl_valid_d;
         fl_addr_q    <= fl_addr_d;
         cpu_ready_q  <= cpu_ready_d;
         cpu_err_q    <= cpu_err_d;
         cpu_rdata_q  <= cpu_rdata_d;
      end
   end

endmodule

// File: doc/flash_word_fetch.md
Name: flash_word_fetch

Overview:
- Sits directly upstream of the SPI flash byte-read controller, between the CPU/bus instruction-fetch port and that controller.
- Turns one 32-bit word read from the CPU into four sequential byte-read handshakes on the flash controller's mem_valid/mem_ready interface.
- Assembles the four bytes little-endian and keeps the last fetched word in a one-entry buffer, so repeated fetches of the same word complete in one cycle.
- Per-byte watchdog: a hung flash transaction returns an error instead of stalling the CPU.

Parameters:
- TIMEOUT_CYCLES, 4096: max cycles fl_valid may wait for fl_ready on one byte before abort; counter width = $clog2(TIMEOUT_CYCLES+1).
- BUF_EN, 1: 1 enables the one-word hit buffer; 0 makes every request a miss.
- ERR_DATA, 32'hFFFF_FFFF: value driven on cpu_rdata with cpu_err.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rstn  in  1  asynchronous, active-high reset; the name is kept as-is to match the codebase.
- cpu_valid  in  1  word request; held high until cpu_ready.
- cpu_addr  in  24  byte address; bits [1:0] ignored (word aligned).
- cpu_rdata  out  32  assembled word; valid while cpu_ready=1.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_err  out  1  high with cpu_ready when the fetch timed out.
- flush  in  1  invalidates the hit buffer.
- fl_valid  out  1  to flash controller mem_valid.
- fl_addr  out  24  to flash controller mem_addr.
- fl_data  in  8  from flash controller mem_data.
- fl_ready  in  1  from flash controller mem_ready.

Behaviour:
- Reset (async, active-high): state=IDLE, cpu_rdata=0, cpu_ready=0, cpu_err=0, fl_valid=0, fl_addr=0, buffer valid=0, tag=0, byte index=0, timer=0.
- States: IDLE, REQ, RELEASE, RESP.
- IDLE, hit:
  - Condition: cpu_valid && BUF_EN && buf_valid && tag==cpu_addr[23:2] && !flush.
  - Next cycle cpu_ready=1 and cpu_rdata=buffer; latency 1.
- IDLE, miss:
  - Latch word address; idx=0; fl_addr={addr[23:2],2'b00}; fl_valid=1; go REQ.
- REQ:
  - fl_valid held at 1; timer increments each cycle.
  - On fl_ready: capture fl_data into byte lane idx (bits 8*idx+7:8*idx), fl_valid=0, timer=0, go RELEASE.
  - If timer reaches TIMEOUT_CYCLES first: fl_valid=0, set timeout flag, go RELEASE.
- RELEASE:
  - Wait for fl_ready==0, which is the flash controller's acknowledge of the dropped valid.
  - If timeout flag is set, or idx==3: go RESP.
  - Otherwise: idx++, fl_addr low bits = idx+1, fl_valid=1, go REQ.
- RESP:
  - Timeout case: cpu_ready=1, cpu_err=1, cpu_rdata=ERR_DATA, buffer invalidated.
  - Normal case: cpu_ready=1, cpu_err=0, cpu_rdata=assembled word; buffer loaded (valid=1, tag=word address) unless a flush was seen during the fetch.
  - Return to IDLE.
- cpu_ready and cpu_err are high for exactly one cycle. A new request is accepted in IDLE no earlier than the cycle after the pulse.
- Byte order is fixed: lowest address first, little-endian word assembly.
- fl_valid never re-asserts in the same cycle fl_ready is high; there is always a RELEASE handshake between bytes.
- cpu_valid dropped mid-fetch: the fetch runs to completion and the buffer is filled; the RESP pulse is suppressed (cpu_ready stays 0).
- flush in IDLE: buf_valid cleared the same edge; a hit is not taken that cycle.
- flush during a fetch: the data is returned to the CPU but not buffered.
- Reset mid-fetch: everything returns to reset values immediately. The flash controller is reset by the same signal.
- Miss latency: sum of the four flash byte transactions + 4 RELEASE handshakes + 1 RESP cycle.

Decomposition:
- Shared package flash_pkg: state encoding localparams (IDLE/REQ/RELEASE/RESP), FLASH_ADDR_W=24, WORD_BYTES=4, default ERR_DATA.
- One natural sub-module, flash_word_buf: tag/valid/data register with lookup, load and flush ports.
- FSM, byte assembly and watchdog stay in flash_word_fetch.

Test Plan:
- Miss, bytes 0x11,0x22,0x33,0x44: cpu_addr=0x000100, flash model returns bytes at 0x100..0x103 -> fl_addr sequence 0x100,0x101,0x102,0x103; cpu_rdata=0x44332211; cpu_err=0; one cpu_ready pulse.
- Hit: repeat cpu_addr=0x000102 immediately after the miss test -> cpu_ready one cycle after cpu_valid, cpu_rdata=0x44332211, no fl_valid activity.
- Flush: assert flush, then request 0x000100 -> full 4-byte miss sequence is reissued.
- Timeout: TIMEOUT_CYCLES=16, flash model never raises ready -> fl_valid drops after 16 cycles; cpu_ready=1, cpu_err=1, cpu_rdata=0xFFFFFFFF; next same-address request misses.
- Abort and reset:
  - Drop cpu_valid after byte 1 -> all 4 bytes still fetched, no cpu_ready; a following request to the same word hits in 1 cycle.
  - Separately, assert rstn during REQ -> fl_valid=0 and cpu_ready=0 asynchronously.
- Handshake checker over all runs: fl_valid never rises while fl_ready=1, and fl_addr is stable while fl_valid=1.
